// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter granting one register-bank write per two cycles
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [2**AW-1:0]     reg_en,
  output logic [DW-1:0]        reg_d,
  output logic                 busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int ENW = 2**AW;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, win, off;
  logic [NREQ-1:0] mask, avail, gnt_nx;
  logic [2*NREQ-1:0] dbl;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data, d_nx;
  logic [ENW-1:0] en_nx;
  logic found, take;
  int sum;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // mask is last cycle's grant, so a stale req is skipped in the IDLE right after WRITE
  always_comb begin
    avail = req & ~mask;
    found = |avail;
    dbl = {avail, avail} >> ptr;
    off = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (dbl[k]) off = PW'(k);
    sum = int'(ptr) + int'(off);
    win = PW'(sum >= NREQ ? sum - NREQ : sum);
    state_nx = (state == IDLE && !stall && found) ? WRITE : IDLE;
  end
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++)
      if (win == PW'(k)) begin
        sel_addr = req_addr[k*AW +: AW];
        sel_data = req_data[k*DW +: DW];
      end
    take = state == IDLE && state_nx == WRITE;
    gnt_nx = take ? NREQ'(1) << win : '0;
    en_nx = take ? ENW'(1) << sel_addr : '0;
    d_nx = take ? sel_data : reg_d;
    ptr_nx = take ? (int'(win) == NREQ-1 ? '0 : win + PW'(1)) : ptr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gnt <= '0;
      reg_en <= '0;
      reg_d <= '0;
      busy <= 1'b0;
      ptr <= '0;
      mask <= '0;
    end else begin
      gnt <= gnt_nx;
      reg_en <= en_nx;
      reg_d <= d_nx;
      busy <= take;
      ptr <= ptr_nx;
      mask <= gnt;
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: per-cycle vector table with expected outputs queued at drive time
module tb_reg_write_arbiter;
  logic clk = 0, reset = 1, stall = 0;
  logic [3:0] req = '0;
  logic [7:0] req_addr = 8'hE4;
  logic [31:0] req_data = 32'h13121110;
  logic [3:0] gnt, reg_en;
  logic [7:0] reg_d;
  logic busy;
  int checks = 0, failures = 0;
  typedef struct { logic [3:0] gnt; logic [3:0] en; logic [7:0] d; logic busy; } exp_t;
  typedef struct { logic stall; logic [3:0] req; logic [7:0] addr; logic [31:0] data; exp_t e; } vec_t;
  exp_t sb[$];
  vec_t tbl[29];
  localparam logic [7:0] A = 8'hE4, A1 = 8'hE6, A2 = 8'h05;
  localparam logic [31:0] D = 32'h13121110, D1 = 32'h131211A5, D2 = 32'h00006655;

  reg_write_arbiter #(.NREQ(4), .AW(2), .DW(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d), .busy(busy));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic [3:0] r, logic [7:0] a, logic [31:0] d,
                              logic [3:0] g, logic [3:0] en, logic [7:0] q, logic b);
    vec_t v;
    v.stall = s; v.req = r; v.addr = a; v.data = d;
    v.e.gnt = g; v.e.en = en; v.e.d = q; v.e.busy = b;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic step(string tag, vec_t v);
    exp_t e;
    stall = v.stall; req = v.req; req_addr = v.addr; req_data = v.data;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
    chk({tag, ".reg_en"}, 32'(reg_en), 32'(e.en));
    chk({tag, ".reg_d"}, 32'(reg_d), 32'(e.d));
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".gnt"}, 32'(gnt), 0);
    chk({tag, ".reg_en"}, 32'(reg_en), 0);
    chk({tag, ".reg_d"}, 32'(reg_d), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  initial begin
    tbl[0]  = mk(0, 4'b1111, A, D, 4'b0001, 4'b0001, 8'h10, 1);
    tbl[1]  = mk(0, 4'b1111, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[2]  = mk(0, 4'b1111, A, D, 4'b0010, 4'b0010, 8'h11, 1);
    tbl[3]  = mk(0, 4'b1111, A, D, 4'b0000, 4'b0000, 8'h11, 0);
    tbl[4]  = mk(0, 4'b1111, A, D, 4'b0100, 4'b0100, 8'h12, 1);
    tbl[5]  = mk(0, 4'b1111, A, D, 4'b0000, 4'b0000, 8'h12, 0);
    tbl[6]  = mk(0, 4'b1111, A, D, 4'b1000, 4'b1000, 8'h13, 1);
    tbl[7]  = mk(0, 4'b1111, A, D, 4'b0000, 4'b0000, 8'h13, 0);
    tbl[8]  = mk(0, 4'b1111, A, D, 4'b0001, 4'b0001, 8'h10, 1);
    tbl[9]  = mk(0, 4'b0000, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[10] = mk(0, 4'b0000, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[11] = mk(0, 4'b0001, A1, D1, 4'b0001, 4'b0100, 8'hA5, 1);
    tbl[12] = mk(0, 4'b0000, A1, D1, 4'b0000, 4'b0000, 8'hA5, 0);
    tbl[13] = mk(0, 4'b0011, A2, D2, 4'b0010, 4'b0010, 8'h66, 1);
    tbl[14] = mk(0, 4'b0001, A2, D2, 4'b0000, 4'b0000, 8'h66, 0);
    tbl[15] = mk(0, 4'b0001, A2, D2, 4'b0001, 4'b0010, 8'h55, 1);
    tbl[16] = mk(0, 4'b0000, A2, D2, 4'b0000, 4'b0000, 8'h55, 0);
    tbl[17] = mk(0, 4'b0000, A, D, 4'b0000, 4'b0000, 8'h55, 0);
    tbl[18] = mk(0, 4'b0001, A, D, 4'b0001, 4'b0001, 8'h10, 1);
    tbl[19] = mk(0, 4'b0001, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[20] = mk(0, 4'b0001, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[21] = mk(0, 4'b0001, A, D, 4'b0001, 4'b0001, 8'h10, 1);
    tbl[22] = mk(0, 4'b0000, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[23] = mk(1, 4'b1010, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[24] = mk(1, 4'b1010, A, D, 4'b0000, 4'b0000, 8'h10, 0);
    tbl[25] = mk(0, 4'b1010, A, D, 4'b0010, 4'b0010, 8'h11, 1);
    tbl[26] = mk(1, 4'b1000, A, D, 4'b0000, 4'b0000, 8'h11, 0);
    tbl[27] = mk(0, 4'b1000, A, D, 4'b1000, 4'b1000, 8'h13, 1);
    tbl[28] = mk(1, 4'b0000, A, D, 4'b0000, 4'b0000, 8'h13, 0);
    #1;
    chk_zero("por");
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 29; i++) step($sformatf("vec%0d", i), tbl[i]);
    #2 reset = 1;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 0;
    step("rw_grant", mk(0, 4'b0100, A, D, 4'b0100, 4'b0100, 8'h12, 1));
    reset = 1;
    #1 chk_zero("reset_in_write");
    @(negedge clk);
    reset = 0;
    step("ptr_zero", mk(0, 4'b1001, A, D, 4'b0001, 4'b0001, 8'h10, 1));
    step("post_rst_w", mk(0, 4'b0100, A, D, 4'b0000, 4'b0000, 8'h10, 0));
    step("regrant2", mk(0, 4'b0100, A, D, 4'b0100, 4'b0100, 8'h12, 1));
    step("final_idle", mk(0, 4'b0000, A, D, 4'b0000, 4'b0000, 8'h12, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
